// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings and SRAM-like bus field widths for the inst/data arbiter.
package sram_like_arbiter_pkg;

    localparam int unsigned SRAM_ADDR_W = 32;
    localparam int unsigned SRAM_DATA_W = 32;
    localparam int unsigned SRAM_STRB_W = 4;
    localparam int unsigned SRAM_SIZE_W = 2;
    localparam int unsigned STARVE_W    = 4;

    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                   wr;
        logic [SRAM_SIZE_W-1:0] size;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_STRB_W-1:0] wstrb;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_cmd_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of 1-bit owner ids for accepted-but-unanswered requests.
module arb_tag_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rptr_q];
    // A full FIFO refuses a push even if a pop frees a slot on the same edge.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= din;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave between the inst and data masters; routes
// responses back in order using a tag FIFO of accepted request owners.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING  = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   resetn,

    input  logic                   inst_sram_req,
    input  logic                   inst_sram_wr,
    input  logic [SRAM_SIZE_W-1:0] inst_sram_size,
    input  logic [SRAM_ADDR_W-1:0] inst_sram_addr,
    input  logic [SRAM_DATA_W-1:0] inst_sram_wdata,
    input  logic [SRAM_STRB_W-1:0] inst_sram_wstrb,
    output logic                   inst_sram_addr_ok,
    output logic                   inst_sram_data_ok,
    output logic [SRAM_DATA_W-1:0] inst_sram_rdata,

    input  logic                   data_sram_req,
    input  logic                   data_sram_wr,
    input  logic [SRAM_SIZE_W-1:0] data_sram_size,
    input  logic [SRAM_ADDR_W-1:0] data_sram_addr,
    input  logic [SRAM_DATA_W-1:0] data_sram_wdata,
    input  logic [SRAM_STRB_W-1:0] data_sram_wstrb,
    output logic                   data_sram_addr_ok,
    output logic                   data_sram_data_ok,
    output logic [SRAM_DATA_W-1:0] data_sram_rdata,

    output logic                   sram_req,
    output logic                   sram_wr,
    output logic [SRAM_SIZE_W-1:0] sram_size,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_wdata,
    output logic [SRAM_STRB_W-1:0] sram_wstrb,
    input  logic                   sram_addr_ok,
    input  logic                   sram_data_ok,
    input  logic [SRAM_DATA_W-1:0] sram_rdata,

    output logic                   resp_err
);

    arb_state_e          state_q, state_d;
    logic                lock_id_q, lock_id_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                resp_err_q, resp_err_d;

    logic      grant_vld, grant_id, granted_req, req_c, accept;
    logic      starve_hit;
    logic      fifo_full, fifo_empty, fifo_head, fifo_pop;
    sram_cmd_t inst_cmd, data_cmd, slave_cmd;

    assign starve_hit = inst_sram_req & (starve_cnt_q == STARVE_W'(STARVE_LIMIT));

    // Grant selection and FREE/LOCKED sequencing.
    always_comb begin
        state_d     = state_q;
        lock_id_d   = lock_id_q;
        grant_vld   = 1'b0;
        grant_id    = ARB_ID_INST;
        granted_req = 1'b0;
        req_c       = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            ARB_FREE: begin
                if (starve_hit) begin
                    grant_vld = 1'b1;
                    grant_id  = ARB_ID_INST;
                end else if (data_sram_req) begin
                    grant_vld = 1'b1;
                    grant_id  = ARB_ID_DATA;
                end else if (inst_sram_req) begin
                    grant_vld = 1'b1;
                    grant_id  = ARB_ID_INST;
                end
            end
            ARB_LOCKED: begin
                grant_vld = 1'b1;
                grant_id  = lock_id_q;
            end
            default: ;
        endcase
        granted_req = grant_vld & ((grant_id == ARB_ID_DATA) ? data_sram_req : inst_sram_req);
        req_c       = granted_req & ~fifo_full;
        accept      = req_c & sram_addr_ok;
        if (state_q == ARB_FREE) begin
            if ((req_c & ~sram_addr_ok) | (granted_req & fifo_full)) begin
                state_d   = ARB_LOCKED;
                lock_id_d = grant_id;
            end
        end else if (accept) begin
            state_d = ARB_FREE;
        end
    end

    // Starvation counter and sticky orphan-response flag.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        resp_err_d   = resp_err_q | (sram_data_ok & fifo_empty);
        if (!inst_sram_req) begin
            starve_cnt_d = '0;
        end else if (accept && grant_id == ARB_ID_INST) begin
            starve_cnt_d = '0;
        end else if (accept && grant_id == ARB_ID_DATA &&
                     starve_cnt_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ARB_FREE;
            lock_id_q    <= ARB_ID_INST;
            starve_cnt_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_id_q    <= lock_id_d;
            starve_cnt_q <= starve_cnt_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign inst_cmd  = '{wr: inst_sram_wr, size: inst_sram_size, addr: inst_sram_addr,
                         wstrb: inst_sram_wstrb, wdata: inst_sram_wdata};
    assign data_cmd  = '{wr: data_sram_wr, size: data_sram_size, addr: data_sram_addr,
                         wstrb: data_sram_wstrb, wdata: data_sram_wdata};
    assign slave_cmd = (grant_vld && grant_id == ARB_ID_DATA) ? data_cmd : inst_cmd;

    assign sram_req   = req_c;
    assign sram_wr    = slave_cmd.wr;
    assign sram_size  = slave_cmd.size;
    assign sram_addr  = slave_cmd.addr;
    assign sram_wstrb = slave_cmd.wstrb;
    assign sram_wdata = slave_cmd.wdata;

    assign inst_sram_addr_ok = accept & (grant_id == ARB_ID_INST);
    assign data_sram_addr_ok = accept & (grant_id == ARB_ID_DATA);

    assign fifo_pop          = sram_data_ok & ~fifo_empty;
    assign inst_sram_data_ok = fifo_pop & (fifo_head == ARB_ID_INST);
    assign data_sram_data_ok = fifo_pop & (fifo_head == ARB_ID_DATA);
    assign inst_sram_rdata   = sram_rdata;
    assign data_sram_rdata   = sram_rdata;
    assign resp_err          = resp_err_q;

    arb_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (fifo_pop),
        .din    (grant_id),
        .dout   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter (OUTSTANDING=4, STARVE_LIMIT=3).
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic [3:0]  inst_sram_wstrb;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [3:0]  data_sram_wstrb;
    logic        sram_req, sram_wr, sram_addr_ok, sram_data_ok;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic [3:0]  sram_wstrb;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
        .resp_err(resp_err)
    );

    task automatic idle_inputs();
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
        inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0; inst_sram_wstrb = 4'h0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
        data_sram_addr = 32'h0; data_sram_wdata = 32'h0; data_sram_wstrb = 4'h0;
        sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (sram_req !== 1'b0) begin n_fail++; $display("FAIL reset_sram_req: got %b exp 0", sram_req); end
        n_checks++; if ({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 4'b0000)
            begin n_fail++; $display("FAIL reset_oks: got %b exp 0000",
                {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}); end
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b exp 0", resp_err); end
        resetn = 1'b1;
    endtask

    task automatic test_single_inst();
        @(negedge clk);
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1FC00000; sram_addr_ok = 1'b1;
        #1;
        n_checks++; if (sram_req !== 1'b1 || sram_addr !== 32'h1FC00000)
            begin n_fail++; $display("FAIL single_req: got req=%b addr=%h exp req=1 addr=1fc00000", sram_req, sram_addr); end
        n_checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10)
            begin n_fail++; $display("FAIL single_addr_ok: got %b exp 10", {inst_sram_addr_ok, data_sram_addr_ok}); end
        @(negedge clk);
        inst_sram_req = 1'b0; sram_addr_ok = 1'b0;
        @(negedge clk);
        sram_data_ok = 1'b1; sram_rdata = 32'h3C080001;
        #1;
        n_checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10 || inst_sram_rdata !== 32'h3C080001)
            begin n_fail++; $display("FAIL single_resp: got ok=%b rdata=%h exp ok=10 rdata=3c080001",
                {inst_sram_data_ok, data_sram_data_ok}, inst_sram_rdata); end
        @(negedge clk);
        sram_data_ok = 1'b0;
        #1;
        n_checks++; if (dut.u_fifo.empty !== 1'b1) begin n_fail++; $display("FAIL single_fifo_empty: got %b exp 1", dut.u_fifo.empty); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        inst_sram_req = 1'b1; inst_sram_addr = 32'h2000;
        data_sram_req = 1'b1; data_sram_addr = 32'h3000; sram_addr_ok = 1'b1;
        #1;
        n_checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b01 || sram_addr !== 32'h3000)
            begin n_fail++; $display("FAIL b2b_first: got ok=%b addr=%h exp ok=01 addr=3000",
                {inst_sram_addr_ok, data_sram_addr_ok}, sram_addr); end
        @(negedge clk);
        data_sram_req = 1'b0;
        #1;
        n_checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10 || sram_addr !== 32'h2000)
            begin n_fail++; $display("FAIL b2b_second: got ok=%b addr=%h exp ok=10 addr=2000",
                {inst_sram_addr_ok, data_sram_addr_ok}, sram_addr); end
        @(negedge clk);
        inst_sram_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'hAAAA0000;
        #1;
        n_checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b01 || data_sram_rdata !== 32'hAAAA0000)
            begin n_fail++; $display("FAIL b2b_resp_data: got ok=%b rdata=%h exp ok=01 rdata=aaaa0000",
                {inst_sram_data_ok, data_sram_data_ok}, data_sram_rdata); end
        @(negedge clk);
        sram_rdata = 32'hBBBB0000;
        #1;
        n_checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10 || inst_sram_rdata !== 32'hBBBB0000)
            begin n_fail++; $display("FAIL b2b_resp_inst: got ok=%b rdata=%h exp ok=10 rdata=bbbb0000",
                {inst_sram_data_ok, data_sram_data_ok}, inst_sram_rdata); end
        @(negedge clk);
        sram_data_ok = 1'b0;
    endtask

    task automatic test_lock();
        logic [3:0] okv;
        @(negedge clk);
        inst_sram_req = 1'b1; inst_sram_addr = 32'h100; sram_addr_ok = 1'b0;
        #1;
        n_checks++; if (sram_req !== 1'b1 || sram_addr !== 32'h100 || inst_sram_addr_ok !== 1'b0)
            begin n_fail++; $display("FAIL lock_c0: got req=%b addr=%h ok=%b exp 1 100 0", sram_req, sram_addr, inst_sram_addr_ok); end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            data_sram_req = 1'b1; data_sram_addr = 32'h200;
            #1;
            n_checks++; if (sram_addr !== 32'h100 || data_sram_addr_ok !== 1'b0)
                begin n_fail++; $display("FAIL lock_hold_c%0d: got addr=%h data_ok=%b exp 100 0", c, sram_addr, data_sram_addr_ok); end
        end
        @(negedge clk);
        sram_addr_ok = 1'b1;
        #1;
        n_checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10 || sram_addr !== 32'h100)
            begin n_fail++; $display("FAIL lock_accept: got ok=%b addr=%h exp 10 100", {inst_sram_addr_ok, data_sram_addr_ok}, sram_addr); end
        @(negedge clk);
        inst_sram_req = 1'b0;
        #1;
        n_checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b01 || sram_addr !== 32'h200)
            begin n_fail++; $display("FAIL lock_data_next: got ok=%b addr=%h exp 01 200", {inst_sram_addr_ok, data_sram_addr_ok}, sram_addr); end
        @(negedge clk);
        data_sram_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1;
        #1;
        okv[3:2] = {inst_sram_data_ok, data_sram_data_ok};
        @(negedge clk);
        #1;
        okv[1:0] = {inst_sram_data_ok, data_sram_data_ok};
        n_checks++; if (okv !== 4'b1001)
            begin n_fail++; $display("FAIL lock_resp_order: got %b exp 1001", okv); end
        @(negedge clk);
        sram_data_ok = 1'b0;
    endtask

    task automatic test_full();
        @(negedge clk);
        inst_sram_req = 1'b1; sram_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_sram_addr = 32'h4000 + 32'(i * 4);
            #1;
            n_checks++; if (inst_sram_addr_ok !== 1'b1)
                begin n_fail++; $display("FAIL full_fill_%0d: got %b exp 1", i, inst_sram_addr_ok); end
            @(negedge clk);
        end
        inst_sram_addr = 32'h4010;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (sram_req !== 1'b0 || inst_sram_addr_ok !== 1'b0)
                begin n_fail++; $display("FAIL full_block_%0d: got req=%b ok=%b exp 0 0", c, sram_req, inst_sram_addr_ok); end
            @(negedge clk);
        end
        sram_data_ok = 1'b1;
        #1;
        n_checks++; if (sram_req !== 1'b0 || inst_sram_data_ok !== 1'b1)
            begin n_fail++; $display("FAIL full_pop_cycle: got req=%b dok=%b exp 0 1", sram_req, inst_sram_data_ok); end
        @(negedge clk);
        sram_data_ok = 1'b0;
        #1;
        n_checks++; if (sram_req !== 1'b1 || inst_sram_addr_ok !== 1'b1 || sram_addr !== 32'h4010)
            begin n_fail++; $display("FAIL full_fifth: got req=%b ok=%b addr=%h exp 1 1 4010", sram_req, inst_sram_addr_ok, sram_addr); end
        @(negedge clk);
        inst_sram_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (inst_sram_data_ok !== 1'b1)
                begin n_fail++; $display("FAIL full_drain_%0d: got %b exp 1", i, inst_sram_data_ok); end
            @(negedge clk);
        end
        sram_data_ok = 1'b0;
        #1;
        n_checks++; if (dut.u_fifo.empty !== 1'b1) begin n_fail++; $display("FAIL full_drained_empty: got %b exp 1", dut.u_fifo.empty); end
    endtask

    task automatic test_starvation();
        logic [7:0] pat;
        logic       prev;
        pat  = 8'b0111_0111;  // bit i = 1 when data should win cycle i
        prev = 1'b0;
        @(negedge clk);
        inst_sram_req = 1'b1; inst_sram_addr = 32'h5000;
        data_sram_req = 1'b1; data_sram_addr = 32'h6000; sram_addr_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sram_data_ok = (i != 0);
            #1;
            n_checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== {~pat[i], pat[i]})
                begin n_fail++; $display("FAIL starve_grant_%0d: got %b exp %b", i,
                    {inst_sram_addr_ok, data_sram_addr_ok}, {~pat[i], pat[i]}); end
            if (i != 0) begin
                n_checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== {~prev, prev})
                    begin n_fail++; $display("FAIL starve_route_%0d: got %b exp %b", i,
                        {inst_sram_data_ok, data_sram_data_ok}, {~prev, prev}); end
            end
            prev = pat[i];
            @(negedge clk);
        end
        inst_sram_req = 1'b0; data_sram_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1;
        #1;
        n_checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10)
            begin n_fail++; $display("FAIL starve_last_resp: got %b exp 10", {inst_sram_data_ok, data_sram_data_ok}); end
        @(negedge clk);
        sram_data_ok = 1'b0;
    endtask

    task automatic test_resp_err_and_reset();
        @(negedge clk);
        sram_data_ok = 1'b1;
        #1;
        n_checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00 || resp_err !== 1'b0)
            begin n_fail++; $display("FAIL orphan_resp: got ok=%b err=%b exp 00 0", {inst_sram_data_ok, data_sram_data_ok}, resp_err); end
        @(negedge clk);
        sram_data_ok = 1'b0;
        #1;
        n_checks++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL resp_err_set: got %b exp 1", resp_err); end
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL resp_err_sticky: got %b exp 1", resp_err); end
        // Burst: one inst accepted, a data request stalled, then an in-flight response.
        inst_sram_req = 1'b1; inst_sram_addr = 32'h7000; sram_addr_ok = 1'b1;
        @(negedge clk);
        inst_sram_req = 1'b0; data_sram_req = 1'b1; data_sram_addr = 32'h8000; sram_addr_ok = 1'b0;
        @(negedge clk);
        sram_data_ok = 1'b1;
        #1;
        n_checks++; if (inst_sram_data_ok !== 1'b1 || sram_req !== 1'b1)
            begin n_fail++; $display("FAIL burst_pre_reset: got dok=%b req=%b exp 1 1", inst_sram_data_ok, sram_req); end
        #2;
        resetn = 1'b0; data_sram_req = 1'b0;
        #1;
        n_checks++; if ({sram_req, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok, resp_err} !== 6'b0)
            begin n_fail++; $display("FAIL async_reset_outputs: got %b exp 000000",
                {sram_req, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok, resp_err}); end
        @(negedge clk);
        sram_data_ok = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        data_sram_req = 1'b1; data_sram_addr = 32'h9000; sram_addr_ok = 1'b1;
        #1;
        n_checks++; if (data_sram_addr_ok !== 1'b1 || sram_addr !== 32'h9000 || resp_err !== 1'b0)
            begin n_fail++; $display("FAIL post_reset_accept: got ok=%b addr=%h err=%b exp 1 9000 0",
                data_sram_addr_ok, sram_addr, resp_err); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_inst();
        test_back_to_back();
        test_lock();
        test_full();
        test_starvation();
        test_resp_err_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
